// File: rtl/blit_pkg.sv
// Shared encodings and default geometry for the rectangle blitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blit_pkg;

    localparam int SCR_W_DEF = 320;
    localparam int SCR_H_DEF = 240;
    localparam int TILE_DEF  = 32;
    localparam int SPR_DEF   = 16;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_TILE   = 2'd1,
        MODE_SPRITE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/blit_addr_gen.sv
// ROM address generator: maps operation mode and pixel counters to a ROM word address.
// Latency: combinational.
// Backpressure: none; follows the counters directly.
module blit_addr_gen
    import blit_pkg::*;
#(
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int TILE = blit_pkg::TILE_DEF,
    parameter int SPR  = blit_pkg::SPR_DEF,
    parameter int AW   = 10
) (
    input  mode_e         mode,
    input  logic [XW-1:0] i,
    input  logic [YW-1:0] j,
    output logic [AW-1:0] rom_addr
);

    // TILE and SPR are powers of two, so the modulo and multiply reduce to bit slicing.
    always_comb begin
        rom_addr = '0;
        case (mode)
            MODE_TILE:   rom_addr = AW'(((int'(j) % TILE) * TILE) + (int'(i) % TILE));
            MODE_SPRITE: rom_addr = AW'((int'(j) * SPR) + int'(i));
            default:     rom_addr = '0;
        endcase
    end

endmodule

// File: rtl/rect_blitter.sv
// Rectangle blitter: FILL / TILE / SPRITE raster walk producing one pixel write per cycle.
// Latency: first pixel 2 cycles after start, done pulse w*h+2 cycles after start.
// Backpressure: none; the pixel port is always accepted, abort cancels immediately.
module rect_blitter
    import blit_pkg::*;
#(
    parameter int SCR_W = blit_pkg::SCR_W_DEF,
    parameter int SCR_H = blit_pkg::SCR_H_DEF,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int CW    = 15,
    parameter int TILE  = blit_pkg::TILE_DEF,
    parameter int SPR   = blit_pkg::SPR_DEF,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] fill_colour,
    input  logic [CW-1:0] key_colour,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          plot
);

    typedef struct packed {
        mode_e         mode;
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [CW-1:0] fill;
        logic [CW-1:0] key;
    } op_t;

    state_e        state;
    op_t           op_q;
    logic [XW-1:0] i;
    logic [YW-1:0] j;
    logic          out_vld;
    logic          plot_q;

    mode_e         mode_in;
    logic [XW-1:0] w_in;
    logic [YW-1:0] h_in;
    logic          degenerate;
    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;
    logic          clipped;
    logic          last_pix;
    logic [AW-1:0] addr;

    assign mode_in = mode_e'(mode);

    always_comb begin
        w_in = w;
        h_in = h;
        if (mode_in == MODE_SPRITE) begin
            if (w > XW'(SPR)) w_in = XW'(SPR);
            if (h > YW'(SPR)) h_in = YW'(SPR);
        end
    end

    assign degenerate = (mode_in == MODE_RSVD) || (w == '0) || (h == '0);

    // One extra bit so coordinates past the screen edge are clipped rather than wrapped.
    assign sum_x    = {1'b0, op_q.x0} + {1'b0, i};
    assign sum_y    = {1'b0, op_q.y0} + {1'b0, j};
    assign clipped  = (sum_x >= (XW+1)'(SCR_W)) || (sum_y >= (YW+1)'(SCR_H));
    assign last_pix = (i == op_q.w - XW'(1)) && (j == op_q.h - YW'(1));

    blit_addr_gen #(
        .XW   (XW),
        .YW   (YW),
        .TILE (TILE),
        .SPR  (SPR),
        .AW   (AW)
    ) u_addr_gen (
        .mode     (op_q.mode),
        .i        (i),
        .j        (j),
        .rom_addr (addr)
    );

    assign rom_addr = (state == ST_RUN) ? addr : '0;
    assign busy     = (state == ST_RUN) || (state == ST_FLUSH);

    // Second stage lines up with the ROM word read for the pixel issued one cycle earlier.
    assign pix_colour = !out_vld ? '0 : ((op_q.mode == MODE_FILL) ? op_q.fill : rom_data);
    assign plot       = plot_q && !((op_q.mode == MODE_SPRITE) && (rom_data == op_q.key));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            i       <= '0;
            j       <= '0;
            out_vld <= 1'b0;
            plot_q  <= 1'b0;
            pix_x   <= '0;
            pix_y   <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_vld <= 1'b0;
                    plot_q  <= 1'b0;
                    done    <= 1'b0;
                    if (start && !abort) begin
                        op_q.mode <= mode_in;
                        op_q.x0   <= x0;
                        op_q.y0   <= y0;
                        op_q.w    <= w_in;
                        op_q.h    <= h_in;
                        op_q.fill <= fill_colour;
                        op_q.key  <= key_colour;
                        i         <= '0;
                        j         <= '0;
                        state     <= degenerate ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        out_vld <= 1'b0;
                        plot_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        out_vld <= 1'b1;
                        plot_q  <= !clipped;
                        pix_x   <= sum_x[XW-1:0];
                        pix_y   <= sum_y[YW-1:0];
                        if (last_pix) begin
                            i     <= '0;
                            j     <= '0;
                            state <= ST_FLUSH;
                        end else if (i == op_q.w - XW'(1)) begin
                            i <= '0;
                            j <= j + YW'(1);
                        end else begin
                            i <= i + XW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    out_vld <= 1'b0;
                    plot_q  <= 1'b0;
                    done    <= !abort;
                    state   <= abort ? ST_IDLE : ST_DONE;
                end
                ST_DONE: begin
                    // Entered from IDLE with an empty rectangle, done is not yet set: show it first.
                    if (done) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_blitter.sv
// Directed bench for rect_blitter: table of operations checked cycle by cycle against a
// reference walk, plus hand sequences for abort, start-while-busy and mid-run reset.
module tb_rect_blitter;

    localparam int SCR_W = 320;
    localparam int SCR_H = 240;
    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 15;
    localparam int TILE  = 32;
    localparam int SPR   = 16;
    localparam int AW    = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
    logic [CW-1:0] fill_colour;
    logic [CW-1:0] key_colour;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] rom_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_colour;
    logic          plot;

    int checks = 0;
    int errors = 0;

    rect_blitter #(
        .SCR_W (SCR_W), .SCR_H (SCR_H), .XW (XW), .YW (YW), .CW (CW),
        .TILE (TILE), .SPR (SPR), .AW (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .x0          (x0),
        .y0          (y0),
        .w           (w),
        .h           (h),
        .fill_colour (fill_colour),
        .key_colour  (key_colour),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .plot        (plot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int rom_word(input int a);
        if (a == 5) return 0;
        return a * 7 + 3;
    endfunction

    always @(posedge clk) rom_data <= CW'(rom_word(int'(rom_addr)));

    function automatic int addr_of(input int md, input int pi, input int pj);
        if (md == 1) return (pj % TILE) * TILE + (pi % TILE);
        if (md == 2) return pj * SPR + pi;
        return 0;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [case %0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int id;
        int md;
        int x0;
        int y0;
        int w;
        int h;
        int fill;
        int key;
        int exp_plots;
        int exp_done;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int we, he, n, dcyc, nplot, p, pi, pj, a;
        logic [31:0] e_addr, e_plot;
        we = v.w;
        he = v.h;
        if (v.md == 2) begin
            if (we > SPR) we = SPR;
            if (he > SPR) he = SPR;
        end
        n = (v.md == 3 || v.w == 0 || v.h == 0) ? 0 : we * he;
        mode = 2'(v.md);
        x0 = XW'(v.x0);
        y0 = YW'(v.y0);
        w = XW'(v.w);
        h = YW'(v.h);
        fill_colour = CW'(v.fill);
        key_colour = CW'(v.key);
        start = 1'b1;
        tick();
        start = 1'b0;
        dcyc = -1;
        nplot = 0;
        for (int k = 0; k <= n + 3; k++) begin
            e_addr = 0;
            if (k < n) e_addr = 32'(addr_of(v.md, k % we, k / we));
            chk("rom_addr", v.id, 32'(rom_addr), e_addr);
            chk("busy", v.id, 32'(busy), (n > 0 && k <= n) ? 32'd1 : 32'd0);
            chk("done", v.id, 32'(done), (k == n + 1) ? 32'd1 : 32'd0);
            e_plot = 0;
            if (k >= 1 && k <= n) begin
                p = k - 1;
                pi = p % we;
                pj = p / we;
                a = addr_of(v.md, pi, pj);
                if (v.x0 + pi < SCR_W && v.y0 + pj < SCR_H &&
                    !(v.md == 2 && rom_word(a) == v.key)) e_plot = 1;
                if (e_plot == 1) begin
                    chk("pix_x", v.id, 32'(pix_x), 32'(v.x0 + pi));
                    chk("pix_y", v.id, 32'(pix_y), 32'(v.y0 + pj));
                    chk("pix_colour", v.id, 32'(pix_colour),
                        32'((v.md == 0) ? v.fill : rom_word(a)));
                end
            end
            chk("plot", v.id, 32'(plot), e_plot);
            if (done && dcyc < 0) dcyc = k + 1;
            if (plot) nplot++;
            tick();
        end
        chk("plot_count", v.id, 32'(nplot), 32'(v.exp_plots));
        chk("done_latency", v.id, 32'(dcyc), 32'(v.exp_done));
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, nplot, nfar, quiet;

        vecs[0] = '{0, 0, 10, 20, 3, 2, 'h7fff, 0, 6, 8};
        vecs[1] = '{1, 1, 0, 0, 64, 1, 0, 0, 64, 66};
        vecs[2] = '{2, 2, 0, 0, 40, 40, 0, 0, 255, 258};
        vecs[3] = '{3, 0, 318, 239, 4, 2, 'h1234, 0, 2, 10};
        vecs[4] = '{4, 0, 10, 10, 0, 5, 'h0111, 0, 0, 2};
        vecs[5] = '{5, 3, 10, 10, 3, 2, 'h0222, 0, 0, 2};
        vecs[6] = '{6, 0, 10, 10, 4, 0, 'h0333, 0, 0, 2};
        vecs[7] = '{7, 2, 100, 50, 3, 2, 0, 'h1234, 6, 8};
        vecs[8] = '{8, 1, 0, 0, 1, 34, 0, 0, 34, 36};

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode = 2'd0;
        x0 = '0;
        y0 = '0;
        w = '0;
        h = '0;
        fill_colour = '0;
        key_colour = '0;
        repeat (3) tick();
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_plot", 0, 32'(plot), 0);
        chk("rst_pix_x", 0, 32'(pix_x), 0);
        chk("rst_pix_y", 0, 32'(pix_y), 0);
        chk("rst_pix_colour", 0, 32'(pix_colour), 0);
        chk("rst_rom_addr", 0, 32'(rom_addr), 0);
        reset = 1'b1;
        tick();

        for (int t = 0; t < 9; t++) run_vec(vecs[t]);

        // Abort while pixel 3 of a 10-pixel fill is being issued.
        mode = 2'd0; x0 = '0; y0 = '0; w = XW'(10); h = YW'(1); fill_colour = CW'('h2aaa);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("busy_pre_abort", 100, 32'(busy), 1);
        chk("plot_pre_abort", 100, 32'(plot), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("busy_after_abort", 100, 32'(busy), 0);
        chk("plot_after_abort", 100, 32'(plot), 0);
        quiet = 1;
        repeat (12) begin
            tick();
            if (done || plot || busy) quiet = 0;
        end
        chk("quiet_after_abort", 100, 32'(quiet), 1);

        // A second start while busy must not disturb the running fill.
        mode = 2'd0; x0 = '0; y0 = '0; w = XW'(4); h = YW'(1); fill_colour = CW'('h0555);
        start = 1'b1;
        tick();
        start = 1'b0;
        dcyc = -1; nplot = 0; nfar = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (plot) nplot++;
            if (plot && pix_x >= XW'(100)) nfar++;
            if (done && dcyc < 0) dcyc = k + 1;
            if (k == 1) begin
                x0 = XW'(100);
                w = XW'(1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_start_plots", 101, 32'(nplot), 4);
        chk("busy_start_stray", 101, 32'(nfar), 0);
        chk("busy_start_done", 101, 32'(dcyc), 6);

        // Abort and start together in IDLE: abort wins.
        x0 = '0; w = XW'(4);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 102, 32'(busy), 0);
        tick();
        chk("abort_start_busy2", 102, 32'(busy), 0);
        chk("abort_start_done", 102, 32'(done), 0);

        // Reset in the middle of a tile run clears every output at once.
        mode = 2'd1; x0 = XW'(50); y0 = YW'(60); w = XW'(10); h = YW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_reset_addr", 103, 32'(rom_addr), 4);
        chk("pre_reset_pix_x", 103, 32'(pix_x), 53);
        reset = 1'b0;
        #1;
        chk("mid_reset_busy", 103, 32'(busy), 0);
        chk("mid_reset_done", 103, 32'(done), 0);
        chk("mid_reset_plot", 103, 32'(plot), 0);
        chk("mid_reset_pix_x", 103, 32'(pix_x), 0);
        chk("mid_reset_pix_y", 103, 32'(pix_y), 0);
        chk("mid_reset_colour", 103, 32'(pix_colour), 0);
        chk("mid_reset_addr", 103, 32'(rom_addr), 0);
        tick();
        reset = 1'b1;
        quiet = 1;
        repeat (12) begin
            tick();
            if (done || plot || busy) quiet = 0;
        end
        chk("quiet_after_reset", 103, 32'(quiet), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_blitter.md
RECT_BLITTER -- requirements
Module: rect_blitter

Interface
REQ-001 SHALL have parameter SCR_W, default 320, screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 240, screen height in pixels.
REQ-003 SHALL have parameter XW, default 9, x coordinate width.
REQ-004 SHALL have parameter YW, default 8, y coordinate width.
REQ-005 SHALL have parameter CW, default 15, colour width.
REQ-006 SHALL have parameter TILE, default 32, tile edge in pixels (power of two).
REQ-007 SHALL have parameter SPR, default 16, sprite edge in pixels (power of two).
REQ-008 SHALL have parameter AW, default 10, ROM address width, with AW >= log2(max(TILE*TILE, SPR*SPR)).
REQ-009 SHALL have port clk, input, 1 bit, the single clock; reset is asynchronous and active-low.
REQ-010 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-011 SHALL have ports start (input, 1 bit) and mode (input, 2 bits): request pulse and operation, where 0=FILL, 1=TILE, 2=SPRITE and 3=reserved.
REQ-012 SHALL have ports x0 (input, XW bits), y0 (input, YW bits), w (input, XW bits) and h (input, YW bits), giving the rectangle origin and size.
REQ-013 SHALL have ports fill_colour (input, CW bits), the FILL colour, and key_colour (input, CW bits), the SPRITE transparent colour.
REQ-014 SHALL have ports abort (input, 1 bit), cancel request; busy (output, 1 bit), operation in progress; and done (output, 1 bit), a one-cycle completion pulse.
REQ-015 SHALL have ports rom_addr (output, AW bits) and rom_data (input, CW bits) for a synchronous ROM with exactly 1-cycle read latency.
REQ-016 SHALL have ports pix_x (output, XW bits), pix_y (output, YW bits), pix_colour (output, CW bits) and plot (output, 1 bit), forming the pixel write port to vga_adapter.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH and DONE.
REQ-018 SHALL, in IDLE with start=1, latch mode, x0, y0, w, h, fill_colour and key_colour, clear the counters i and j, and enter RUN; start SHALL be ignored outside IDLE.
REQ-019 SHALL, when mode=3 or w=0 or h=0, go directly from IDLE to DONE, with no plot asserted.
REQ-020 SHALL, in SPRITE mode, clamp the latched w and h to SPR.
REQ-021 SHALL, in RUN, issue one pixel (i,j) per cycle in raster order: i increments, and on i=w-1 i wraps to 0 and j increments; issuing (w-1,h-1) moves the state to FLUSH.
REQ-022 SHALL, in TILE mode, drive rom_addr = (j mod TILE)*TILE + (i mod TILE).
REQ-023 SHALL, in SPRITE mode, drive rom_addr = j*SPR + i.
REQ-024 SHALL, in FILL mode, hold rom_addr at 0.
REQ-025 SHALL have a two-stage pipeline: a pixel issued in cycle n appears on pix_x/pix_y/pix_colour/plot in cycle n+1, aligned with rom_data.
REQ-026 SHALL compute pix_x = x0+i and pix_y = y0+j, each at XW+1 and YW+1 bits internally, truncated to XW/YW bits on output.
REQ-027 SHALL take pix_colour from fill_colour in FILL mode and from rom_data in TILE and SPRITE modes.
REQ-028 SHALL deassert plot for clipped pixels, where x0+i >= SCR_W or y0+j >= SCR_H; clipped pixels still consume their cycle.
REQ-029 SHALL, in SPRITE mode, deassert plot when rom_data == key_colour.
REQ-030 SHALL spend exactly one cycle in FLUSH, output the last pixel there, and then enter DONE.
REQ-031 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE.
REQ-032 SHALL hold busy=1 in RUN and FLUSH and busy=0 in IDLE and DONE.
REQ-033 SHALL take w*h+2 cycles from the start edge to done.
REQ-034 SHALL, on abort=1 in RUN or FLUSH, go to IDLE on the next edge, with plot=0 from that edge, no done pulse, and any pipelined pixel discarded.
REQ-035 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-036 SHALL hold plot=0 whenever the state is not RUN(pipelined) or FLUSH.

Reset
REQ-037 SHALL, on reset=0 asynchronously, set state=IDLE, i=j=0, busy=0, done=0, plot=0, pix_x=0, pix_y=0, pix_colour=0 and rom_addr=0.
REQ-038 SHALL, when reset is asserted mid-operation, drop the operation with no done pulse and no further plot.

Structure
REQ-039 SHALL place the mode encodings (FILL, TILE, SPRITE, reserved) and the state encodings in shared package blit_pkg.
REQ-040 SHALL place the default SCR_W, SCR_H, TILE and SPR constants in blit_pkg.
REQ-041 SHALL implement address generation (mode, i, j -> rom_addr) as one combinational sub-module, blit_addr_gen.
REQ-042 SHALL keep ROM instances external, muxed by the caller.

Verification
REQ-043 SHALL cover FILL: x0=10, y0=20, w=3, h=2, colour 7FFF -> 6 plots (10,20)..(12,21) in raster order, the first plot 2 cycles after start, and done 8 cycles after start.
REQ-044 SHALL cover TILE: x0=0, y0=0, w=64, h=1 -> rom_addr sequence 0..31, 0..31, with pix_colour equal to the ROM word one cycle later.
REQ-045 SHALL cover SPRITE clamp with key: w=40, h=40, key=0000, ROM word 5 = 0000 -> 256 pixel slots, with plot=0 at the slot for i=5, j=0.
REQ-046 SHALL cover clipping: x0=318, y0=239, w=4, h=2, FILL -> only (318,239) and (319,239) plotted, 8 slots, done asserted.
REQ-047 SHALL cover the degenerate cases: w=0 -> done 2 cycles after start with no plot; mode=3 -> the same.
REQ-048 SHALL cover abort and reset: abort at pixel 3 of a 10-pixel FILL -> busy=0 next cycle, no done; start while busy is ignored; reset mid-RUN -> all outputs 0 immediately.
